// File: rtl/gray_decoder.sv
// Registered Gray-to-binary decoder with valid/ready handshake on both sides.
// Define GRAY_STEP_CHECK_EN to add the step checker (step_err, dir, err_cnt).
module gray_decoder #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] gray_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] bin_out,
   output logic             step_err,
   output logic             dir,
   output logic [7:0]       err_cnt
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int unsigned i = WIDTH-1; i > 0; i--) begin
         b[i-1] = b[i] ^ g[i-1];
      end
      return b;
   endfunction

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] bin_new;
   logic             accept;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign bin_new   = gray2bin(gray_in);
   assign out_valid = out_valid_q;
   assign bin_out   = bin_q;

   // A consume and a new accept on the same edge keep out_valid high.
   always_comb begin
      out_valid_d = out_valid_q;
      bin_d       = bin_q;
      if (accept) begin
         out_valid_d = 1'b1;
         bin_d       = bin_new;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         bin_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         bin_q       <= bin_d;
      end
   end

`ifdef GRAY_STEP_CHECK_EN
   typedef enum logic {ST_FIRST, ST_TRACK} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic             step_err_q, step_err_d;
   logic             dir_q, dir_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] bin_prev;
   logic             multi_bit;

   assign diff      = gray_in ^ prev_q;
   // More than one set bit iff clearing the lowest set bit leaves something.
   assign multi_bit = |(diff & (diff - ONE));
   assign bin_prev  = gray2bin(prev_q);

   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      step_err_d = step_err_q;
      dir_d      = dir_q;
      err_cnt_d  = err_cnt_q;
      if (accept) begin
         prev_d  = gray_in;
         state_d = ST_TRACK;
         if (state_q == ST_FIRST) begin
            step_err_d = 1'b0;
            dir_d      = 1'b0;
         end else if (multi_bit) begin
            step_err_d = 1'b1;
            dir_d      = 1'b0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
         end else begin
            step_err_d = 1'b0;
            dir_d      = (bin_new == bin_prev + ONE);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FIRST;
         prev_q     <= '0;
         step_err_q <= 1'b0;
         dir_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         step_err_q <= step_err_d;
         dir_q      <= dir_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign step_err = step_err_q;
   assign dir      = dir_q;
   assign err_cnt  = err_cnt_q;
`else
   assign step_err = 1'b0;
   assign dir      = 1'b0;
   assign err_cnt  = '0;
`endif

endmodule
